datamem_burst_master: RTL and testbench
=======================================

# datamem_burst_master

Initiator-side controller for the 2-D `datamem` array. It accepts burst read/write requests on a valid/ready command channel and streams write data in and read data out. It drives the memory's X/Y address, write-enable and data-in ports, and captures its one-cycle-latency `Data_out`. It sits between the load/store pipeline and `datamem`, and converts linear burst addresses into row/column coordinates.

## Interface
- `ADDR_BITS`, 4, width of each of the X and Y memory addresses; the linear address is 2*ADDR_BITS.
- `DATA_WIDTH`, 8, word width.
- `LEN_BITS`, 4, width of the burst-length field; a burst is 1..2^LEN_BITS beats.

Ports:
- `Clock`  in  1  rising-edge clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when both valid and ready are high.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  2*ADDR_BITS  start address {X,Y}; X is the upper ADDR_BITS.
- `req_len`  in  LEN_BITS  number of beats minus 1.
- `wr_valid` / `wr_ready` / `wr_data`  in / out / in  1 / 1 / DATA_WIDTH  write-data stream.
- `rd_valid` / `rd_ready` / `rd_data`  out / in / out  1 / 1 / DATA_WIDTH  read-data stream.
- `busy`  out  1  high whenever the block is not IDLE.
- `done`  out  1  one-cycle pulse when a burst completes.
- `mem_we`  out  1  drives `datamem.WriteEnable`.
- `mem_x_addr`, `mem_y_addr`  out  ADDR_BITS each  drive `X_addr` and `Y_addr`.
- `mem_wdata`  out  DATA_WIDTH  drives `Data_in`.
- `mem_rdata`  in  DATA_WIDTH  from `Data_out`; this data is registered by the memory and is valid one cycle after its address is presented.

## Operation

**States:** IDLE, WRITE, READ, DRAIN.
- **IDLE:** `req_ready` = ~Reset. On accept, latch the address into a 2*ADDR_BITS address counter and `req_len` into a beat counter, then go to WRITE or READ according to `req_write`.
- **WRITE:**
  - `wr_ready` = 1.
  - `mem_we` = `wr_valid`, combinational.
  - `mem_wdata` = `wr_data`.
  - Each accepted beat increments the address and decrements the beat counter.
  - The final beat returns the state to IDLE and registers `done`.
  - Gaps in `wr_valid` stall the burst without producing writes.
- **READ:**
  - `mem_we` = 0.
  - Issue a read (address on the mem ports, address counter advances) when fifo_count + inflight − pop < 2. Here pop = `rd_valid` & `rd_ready` in the same cycle.
  - `inflight` is a 1-bit register set on issue. In the following cycle `mem_rdata` is pushed into a 2-entry response FIFO and `inflight` clears, unless a new issue occurs.
  - After the final issue, go to DRAIN.
- **DRAIN:** no issues. Exit to IDLE at the edge where the last beat is popped with `inflight` = 0, and register `done`.

**Address arithmetic:**
- The linear address {X,Y} increments by 1 per beat: Y+1, and when Y wraps to 0, X+1.
- The address wraps modulo 2^(2*ADDR_BITS), so {all-ones} is followed by 0.
- Outside bursts, `mem_x_addr` and `mem_y_addr` hold the last counter value.

**Read-data stream:**
- `rd_valid` = FIFO non-empty; `rd_data` = FIFO head.
- Order is preserved.
- Data is never dropped under any `rd_ready` pattern.

**Reset (any state, including mid-burst):**
- State goes to IDLE.
- FIFO is emptied, `inflight` cleared, counters zeroed.
- Outstanding read data is discarded.

**Reset values of outputs:**
- `req_ready` = 0 while Reset is high, and 1 in the first cycle after.
- `wr_ready`, `rd_valid`, `busy`, `done` and `mem_we` are 0.
- `rd_data`, `mem_wdata`, `mem_x_addr` and `mem_y_addr` are 0.

**Simultaneous events:**
- `done` and a new `req_valid` in the same IDLE cycle: the request is accepted.
- FIFO push and pop in the same cycle: the count is unchanged.

## Timing
- Request accepted at edge N; the state becomes WRITE or READ in cycle N+1.
- **Write:**
  - The first write can commit to memory at edge N+2, when `wr_valid` is high in cycle N+1.
  - One beat per cycle at full rate.
  - `done` is high in the cycle after the final beat edge.
- **Read:**
  - The first issue is in cycle N+1 and the first `rd_valid` is in cycle N+2.
  - Sustained rate is 1 beat/cycle while `rd_ready` = 1.
  - `done` is high in the cycle after the final pop.
- At most 2 beats are outstanding (FIFO + inflight) at any time.
- `busy` is high from cycle N+1 through the final-beat cycle, and low in the `done` cycle.

## Test plan
1. Write burst, addr 0x0E, len 3, data A0..A3 with `wr_valid` held high: `mem_we` is high for 4 cycles at (0,14), (0,15), (1,0), (1,1). `done` pulses once, the cycle after the 4th beat.
2. Read burst, addr 0x0E, len 3, `rd_ready` = 1: `rd_data` = A0, A1, A2, A3 on consecutive cycles, starting 2 cycles after accept. `done` pulses the cycle after A3.
3. Same read with `rd_ready` low for 5 cycles after the first `rd_valid`: at most 2 beats are outstanding and no issue occurs while full. The order A0..A3 is intact and no beat is duplicated.
4. Wrap: write len 1 at 0xFF with data 5A, 5B, then read back: writes land at (15,15) and (0,0), and the read returns 5A, 5B.
5. Write burst with `wr_valid` pattern 1,0,0,1,1,0,1 for len 3: exactly 4 `mem_we` pulses, coincident with the valid cycles, at consecutive addresses.
6. Reset for 1 cycle after 2 beats of a len-7 read: `rd_valid`, `busy` and `done` are 0. `req_ready` is 1 the next cycle. A subsequent read of 0x0E, len 0, returns A0.

Source files
------------

// File: rtl/datamem_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : datamem_burst_master_if
//  Brief    : Command, write-data, read-data and memory-port bundle for the
//             datamem burst master. The master modport is the controller's
//             view; the slave modport is the view of the pipeline/memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface datamem_burst_master_if #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_BITS   = 4
);
  // command channel
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [2*ADDR_BITS-1:0]   req_addr;
  logic [LEN_BITS-1:0]      req_len;
  // write-data stream
  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_WIDTH-1:0]    wr_data;
  // read-data stream
  logic                     rd_valid;
  logic                     rd_ready;
  logic [DATA_WIDTH-1:0]    rd_data;
  // status
  logic                     busy;
  logic                     done;
  // datamem ports
  logic                     mem_we;
  logic [ADDR_BITS-1:0]     mem_x_addr;
  logic [ADDR_BITS-1:0]     mem_y_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    output req_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output busy, done,
    output mem_we, mem_x_addr, mem_y_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    input  req_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  busy, done,
    input  mem_we, mem_x_addr, mem_y_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/datamem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : datamem_burst_master
//  Brief    : Burst read/write initiator for the 2-D datamem array. Converts a
//             linear {X,Y} start address plus beat count into per-beat memory
//             accesses, streams write data straight to the memory and returns
//             read data through a 2-entry fall-through response FIFO.
//  Revision : 1.0  initial release
// ============================================================================
module datamem_burst_master #(
  parameter int ADDR_BITS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_BITS   = 4
) (
  input  wire logic              Clock,
  input  wire logic              Reset,
  datamem_burst_master_if.master bus
);

  localparam int                   c_lin_bits = 2 * ADDR_BITS;
  localparam logic [c_lin_bits-1:0] c_addr_one = c_lin_bits'(1);
  localparam logic [LEN_BITS-1:0]   c_len_one  = LEN_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [c_lin_bits-1:0]   addr_q, addr_d;
  logic [LEN_BITS-1:0]     len_q, len_d;
  logic                    done_q, done_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   fifo_q [2];
  logic [DATA_WIDTH-1:0]   fifo_d [2];

  logic                    w_run;
  logic                    w_req_fire;
  logic                    w_mem_we;
  logic                    w_fifo_empty;
  logic                    w_rd_valid;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_issue;
  logic [2:0]              w_level;

  // Handshake qualifiers and read-side occupancy. The inflight beat counts as
  // already present: its data appears on mem_rdata this cycle and is forwarded
  // when the FIFO is empty, which gives the two-cycle accept-to-data latency.
  always_comb begin
    w_run        = ~Reset;
    w_req_fire   = w_run && (state_q == S_IDLE) && bus.req_valid;
    w_mem_we     = w_run && (state_q == S_WRITE) && bus.wr_valid;
    w_fifo_empty = (cnt_q == 2'd0);
    w_rd_valid   = w_run && (!w_fifo_empty || inflight_q);
    w_pop        = w_rd_valid && bus.rd_ready;
    w_push       = inflight_q;
    w_level      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, w_pop};
    w_issue      = w_run && (state_q == S_READ) && (w_level < 3'd2);
  end

  // Burst sequencing: address/beat counters and state transitions.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req_fire) begin
          addr_d  = bus.req_addr;
          len_d   = bus.req_len;
          state_d = bus.req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_mem_we) begin
          addr_d = addr_q + c_addr_one;
          if (len_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            len_d = len_q - c_len_one;
          end
        end
      end
      S_READ: begin
        if (w_issue) begin
          addr_d = addr_q + c_addr_one;
          if (len_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            len_d = len_q - c_len_one;
          end
        end
      end
      S_DRAIN: begin
        // nothing left to issue; finish once the final beat leaves
        if (w_pop && (w_level == 3'd0)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response FIFO bookkeeping; a push into an empty FIFO that is popped in the
  // same cycle bypasses storage entirely.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = w_issue;
    cnt_d      = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    if (w_push && !(w_fifo_empty && w_pop)) begin
      fifo_d[wr_ptr_q] = bus.mem_rdata;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (w_pop && !w_fifo_empty) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // State and datapath registers; reset discards any outstanding read data.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  assign bus.req_ready  = w_run && (state_q == S_IDLE);
  assign bus.wr_ready   = w_run && (state_q == S_WRITE);
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wdata  = (state_q == S_WRITE) ? bus.wr_data : '0;
  assign bus.mem_x_addr = addr_q[c_lin_bits-1:ADDR_BITS];
  assign bus.mem_y_addr = addr_q[ADDR_BITS-1:0];
  assign bus.rd_valid   = w_rd_valid;
  assign bus.rd_data    = !w_fifo_empty ? fifo_q[rd_ptr_q] :
                          inflight_q    ? bus.mem_rdata    : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_datamem_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datamem_burst_master
//  Brief    : Self-checking bench for datamem_burst_master with a datamem
//             stand-in and an array-based expected-memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_datamem_burst_master;

  localparam int AB = 4;
  localparam int DW = 8;
  localparam int LB = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] mem_arr [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] wbuf    [16];

  always #5 clk = ~clk;

  datamem_burst_master_if #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .LEN_BITS(LB)) bus ();

  datamem_burst_master #(.ADDR_BITS(AB), .DATA_WIDTH(DW), .LEN_BITS(LB)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // datamem stand-in: synchronous write, registered one-cycle read
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= DW'(i * 37 + 5);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_we) mem_arr[{bus.mem_x_addr, bus.mem_y_addr}] <= bus.mem_wdata;
      bus.mem_rdata <= mem_arr[{bus.mem_x_addr, bus.mem_y_addr}];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // vmode: 0 = wr_valid always high, 1 = random, 2 = bit pattern vpat then high
  task automatic do_write(input logic [7:0] addr, input int len, input int vmode,
                          input logic [15:0] vpat);
    int         beat   = 0;
    int         cyc    = 0;
    int         pulses = 0;
    logic [7:0] ea;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = addr;
    bus.req_len   = len[LB-1:0];
    #1;
    check("wr_req_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    check("wr_busy", bus.busy, 1);
    check("wr_ready", bus.wr_ready, 1);
    while (beat <= len && cyc < 64) begin
      logic v;
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = 1'($urandom_range(0, 1));
      else                 v = (cyc < 16) ? vpat[cyc] : 1'b1;
      bus.wr_valid = v;
      bus.wr_data  = wbuf[beat];
      #1;
      check("wr_mem_we", bus.mem_we, v);
      if (v) begin
        ea = addr + beat[7:0];
        check("wr_addr", {bus.mem_x_addr, bus.mem_y_addr}, ea);
        check("wr_data", bus.mem_wdata, wbuf[beat]);
        ref_mem[ea] = wbuf[beat];
        pulses++;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.wr_valid = 1'b0;
    #1;
    check("wr_in_time", cyc < 64, 1);
    check("wr_pulses", pulses, len + 1);
    check("wr_done", bus.done, 1);
    check("wr_busy_at_done", bus.busy, 0);
    check("wr_ready_at_done", bus.wr_ready, 0);
    @(negedge clk);
    check("wr_done_single", bus.done, 0);
  endtask

  // rmode: 0 = rd_ready high, 1 = random, 2 = low 5 cycles from first rd_valid
  task automatic do_read(input logic [7:0] addr, input int len, input int rmode);
    int         idx      = 1;
    int         popped   = 0;
    int         first_v  = 0;
    int         last_pop = 0;
    int         done_idx = 0;
    int         issued;
    logic [7:0] lin;
    logic [7:0] ea;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = len[LB-1:0];
    #1;
    check("rd_req_ready", bus.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rd_busy", bus.busy, 1);
    while (done_idx == 0 && idx < 200) begin
      logic rr;
      if (bus.rd_valid === 1'b1 && first_v == 0) first_v = idx;
      if (bus.done === 1'b1) begin
        done_idx = idx;
        check("rd_busy_at_done", bus.busy, 0);
        check("rd_valid_at_done", bus.rd_valid, 0);
      end else begin
        if (rmode == 0)      rr = 1'b1;
        else if (rmode == 1) rr = 1'($urandom_range(0, 1));
        else                 rr = !(first_v != 0 && idx < first_v + 5);
        bus.rd_ready = rr;
        lin    = {bus.mem_x_addr, bus.mem_y_addr};
        issued = int'(8'(lin - addr));
        check("rd_outstanding_le2", (issued - popped) <= 2, 1);
        if (bus.rd_valid === 1'b1 && rr) begin
          ea = addr + popped[7:0];
          check("rd_data", bus.rd_data, ref_mem[ea]);
          popped++;
          last_pop = idx;
        end
      end
      @(negedge clk);
      idx++;
    end
    bus.rd_ready = 1'b0;
    check("rd_done_seen", done_idx != 0, 1);
    check("rd_beats", popped, len + 1);
    check("rd_done_after_last_pop", done_idx, last_pop + 1);
    if (rmode == 0) begin
      check("rd_first_valid_latency", first_v, 2);
      check("rd_full_rate", last_pop, len + 2);
    end
    check("rd_done_single", bus.done, 0);
  endtask

  initial begin
    int pops;
    int cyc;
    rst           = 1'b1;
    mem_init      = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i * 37 + 5);

    // reset state
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_x_addr", bus.mem_x_addr, 0);
    check("rst_y_addr", bus.mem_y_addr, 0);
    rst = 1'b0;
    #1;
    check("rst_release_req_ready", bus.req_ready, 1);

    // 1: write A0..A3 at 0x0E
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
    do_write(8'h0E, 3, 0, 16'h0000);
    // 2: read it back at full rate
    do_read(8'h0E, 3, 0);
    // 3: same read with a back-pressure window
    do_read(8'h0E, 3, 2);
    // 4: address wrap
    wbuf[0] = 8'h5A;
    wbuf[1] = 8'h5B;
    do_write(8'hFF, 1, 0, 16'h0000);
    do_read(8'hFF, 1, 0);
    // 5: gappy write valid 1,0,0,1,1,0,1
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hC0 + 8'(i);
    do_write(8'h40, 3, 2, 16'h0059);
    do_read(8'h40, 3, 1);

    // 6: reset in the middle of a len-7 read
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h20;
    bus.req_len   = 4'd7;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    pops = 0;
    cyc  = 0;
    while (pops < 2 && cyc < 20) begin
      if (bus.rd_valid === 1'b1) pops++;
      @(negedge clk);
      cyc++;
    end
    check("mid_reset_pops_before", pops, 2);
    rst = 1'b1;
    #1;
    check("mid_reset_req_ready_low", bus.req_ready, 0);
    @(negedge clk);
    rst          = 1'b0;
    bus.rd_ready = 1'b0;
    #1;
    check("mid_reset_rd_valid", bus.rd_valid, 0);
    check("mid_reset_busy", bus.busy, 0);
    check("mid_reset_done", bus.done, 0);
    check("mid_reset_req_ready", bus.req_ready, 1);
    do_read(8'h0E, 0, 0);

    // randomized bursts against the expected-memory model
    for (int t = 0; t < 12; t++) begin
      logic [7:0] a;
      int         l;
      a = 8'($urandom);
      l = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1, 16'h0000);
      else                           do_read(a, l, int'($urandom_range(0, 2)));
      do_read(a, l, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
